mux_rr_scheduler: RTL and testbench

Two-lane buffered round-robin scheduler that feeds the 2:1 byte mux path. Each 8-bit input lane is queued in its own small FIFO. A fair arbiter picks one lane per transfer and presents the word on a registered output with a valid/ready handshake. Per-lane pause flags give upstream producers flow control.

---
 rtl/mux_rr_scheduler.sv | 145 ++++++++++++++
 tb/tb_mux_rr_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mux_rr_scheduler.sv
// Two-lane buffered round-robin scheduler: per-lane FIFOs feeding
// a registered valid/ready output stage with alternating grants.
module mux_rr_scheduler #(
   parameter int DATA_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int AFULL_THRESH = 3
) (
   input  logic                  clk2f,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in_0,
   input  logic                  valid_in_0,
   input  logic [DATA_WIDTH-1:0] data_in_1,
   input  logic                  valid_in_1,
   input  logic                  ready_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  sel_out,
   output logic                  pause_0,
   output logic                  pause_1,
   output logic                  overflow_0,
   output logic                  overflow_1
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);

   logic [DATA_WIDTH-1:0] mem_q [2][FIFO_DEPTH];
   logic [AW-1:0]         wptr_q [2];
   logic [AW-1:0]         wptr_d [2];
   logic [AW-1:0]         rptr_q [2];
   logic [AW-1:0]         rptr_d [2];
   logic [CW-1:0]         count_q [2];
   logic [CW-1:0]         count_d [2];
   logic [1:0]            ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  sel_q, sel_d;
   logic                  last_q, last_d;

   logic [DATA_WIDTH-1:0] din [2];
   logic [1:0]            vin;
   logic [1:0]            full;
   logic [1:0]            ne;
   logic [1:0]            push;
   logic [1:0]            pop;
   logic                  load;
   logic                  gnt_v;
   logic                  gnt_l;

   assign din[0] = data_in_0;
   assign din[1] = data_in_1;
   assign vin    = {valid_in_1, valid_in_0};

   // Arbitration: alternate on contention, otherwise serve the lone requester
   always_comb begin
      load  = !valid_q || ready_out;
      gnt_v = 1'b0;
      gnt_l = 1'b0;
      for (int n = 0; n < 2; n++) begin
         full[n] = (count_q[n] == FULL_CNT);
         ne[n]   = (count_q[n] != '0);
      end
      if (load) begin
         if (ne[0] && ne[1]) begin
            gnt_v = 1'b1;
            gnt_l = !last_q;
         end else if (ne[0]) begin
            gnt_v = 1'b1;
            gnt_l = 1'b0;
         end else if (ne[1]) begin
            gnt_v = 1'b1;
            gnt_l = 1'b1;
         end
      end
   end

   // FIFO bookkeeping and output-stage next state
   always_comb begin
      data_d  = data_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      last_d  = last_q;
      for (int n = 0; n < 2; n++) begin
         push[n]    = !reset && vin[n] && !full[n];
         pop[n]     = gnt_v && (gnt_l == 1'(n));
         count_d[n] = count_q[n] + CW'(push[n]) - CW'(pop[n]);
         wptr_d[n]  = wptr_q[n] + AW'(push[n]);
         rptr_d[n]  = rptr_q[n] + AW'(pop[n]);
         ovf_d[n]   = ovf_q[n] | (vin[n] & full[n]);
      end
      if (load) begin
         valid_d = gnt_v;
         if (gnt_v) begin
            data_d = mem_q[gnt_l][rptr_q[gnt_l]];
            sel_d  = gnt_l;
            last_d = gnt_l;
         end
      end
   end

   // Lane storage; pointers and counts live in the control register below
   always_ff @(posedge clk2f) begin
      for (int n = 0; n < 2; n++) begin
         if (push[n]) mem_q[n][wptr_q[n]] <= din[n];
      end
   end

   // Control state with synchronous reset overriding all traffic
   always_ff @(posedge clk2f) begin
      if (reset) begin
         for (int n = 0; n < 2; n++) begin
            wptr_q[n]  <= '0;
            rptr_q[n]  <= '0;
            count_q[n] <= '0;
         end
         ovf_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sel_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         for (int n = 0; n < 2; n++) begin
            wptr_q[n]  <= wptr_d[n];
            rptr_q[n]  <= rptr_d[n];
            count_q[n] <= count_d[n];
         end
         ovf_q   <= ovf_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
      end
   end

   assign data_out   = data_q;
   assign valid_out  = valid_q;
   assign sel_out    = sel_q;
   assign pause_0    = (count_q[0] >= AFULL_CNT);
   assign pause_1    = (count_q[1] >= AFULL_CNT);
   assign overflow_0 = ovf_q[0];
   assign overflow_1 = ovf_q[1];

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler with an ordered scoreboard
// of {sel, data} checked at every output handshake.
module tb_mux_rr_scheduler;

   logic       clk2f = 1'b0;
   logic       reset;
   logic [7:0] data_in_0, data_in_1;
   logic       valid_in_0, valid_in_1;
   logic       ready_out;
   logic [7:0] data_out;
   logic       valid_out, sel_out;
   logic       pause_0, pause_1;
   logic       overflow_0, overflow_1;

   int         n_pass  = 0;
   int         n_total = 0;
   logic [8:0] sb [$];

   mux_rr_scheduler #(
      .DATA_WIDTH(8),
      .FIFO_DEPTH(4),
      .AFULL_THRESH(3)
   ) dut (
      .clk2f(clk2f),
      .reset(reset),
      .data_in_0(data_in_0),
      .valid_in_0(valid_in_0),
      .data_in_1(data_in_1),
      .valid_in_1(valid_in_1),
      .ready_out(ready_out),
      .data_out(data_out),
      .valid_out(valid_out),
      .sel_out(sel_out),
      .pause_0(pause_0),
      .pause_1(pause_1),
      .overflow_0(overflow_0),
      .overflow_1(overflow_1)
   );

   always #5 clk2f = ~clk2f;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Drive one cycle from a negedge, score any handshake, end on next negedge
   task automatic cyc(input logic r, input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1, input logic rdy);
      logic [8:0] e;
      reset      = r;
      valid_in_0 = v0;
      data_in_0  = d0;
      valid_in_1 = v1;
      data_in_1  = d1;
      ready_out  = rdy;
      #1;
      if (!r && valid_out === 1'b1 && ready_out) begin
         if (sb.size() == 0) begin
            chk("unexpected_word", {23'd0, sel_out, data_out}, 32'h1ff);
         end else begin
            e = sb.pop_front();
            chk("xfer", {23'd0, sel_out, data_out}, {23'd0, e});
         end
      end
      @(posedge clk2f);
      @(negedge clk2f);
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound && sb.size() != 0; i++)
         cyc(0, 0, 8'h00, 0, 8'h00, 1);
      chk("drain_empty", sb.size(), 0);
   endtask

   initial begin
      reset = 1'b1;
      valid_in_0 = 1'b0;
      valid_in_1 = 1'b0;
      data_in_0 = '0;
      data_in_1 = '0;
      ready_out = 1'b0;
      @(negedge clk2f);

      // reset with both lanes requesting
      cyc(1, 1, 8'hEE, 1, 8'hDD, 0);
      cyc(1, 1, 8'hEE, 1, 8'hDD, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_sel", sel_out, 0);
      chk("rst_pause", {pause_1, pause_0}, 0);
      chk("rst_ovf", {overflow_1, overflow_0}, 0);
      cyc(0, 0, 8'h00, 0, 8'h00, 1);
      cyc(0, 0, 8'h00, 0, 8'h00, 1);
      chk("rst_no_write", valid_out, 0);

      // single lane, latency and back-to-back throughput
      sb.push_back({1'b0, 8'h11});
      cyc(0, 1, 8'h11, 0, 8'h00, 1);
      chk("lat_not_yet", valid_out, 0);
      sb.push_back({1'b0, 8'h22});
      cyc(0, 1, 8'h22, 0, 8'h00, 1);
      chk("lat_valid", valid_out, 1);
      chk("lat_data", data_out, 8'h11);
      sb.push_back({1'b0, 8'h33});
      cyc(0, 1, 8'h33, 0, 8'h00, 1);
      drain(10);
      chk("single_idle", valid_out, 0);

      // contention fairness after reset
      cyc(1, 0, 8'h00, 0, 8'h00, 0);
      cyc(0, 1, 8'hA0, 1, 8'hB0, 0);
      cyc(0, 1, 8'hA1, 1, 8'hB1, 0);
      cyc(0, 1, 8'hA2, 1, 8'hB2, 0);
      for (int i = 0; i < 3; i++) begin
         sb.push_back({1'b0, 8'hA0 + 8'(i)});
         sb.push_back({1'b1, 8'hB0 + 8'(i)});
      end
      drain(12);
      chk("fair_idle", valid_out, 0);

      // backpressure hold
      cyc(0, 1, 8'h5A, 0, 8'h00, 0);
      cyc(0, 1, 8'h6B, 0, 8'h00, 0);
      sb.push_back({1'b0, 8'h5A});
      sb.push_back({1'b0, 8'h6B});
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 8'h00, 0, 8'h00, 0);
         chk("bp_data", data_out, 8'h5A);
         chk("bp_sel", sel_out, 0);
         chk("bp_valid", valid_out, 1);
      end
      cyc(0, 0, 8'h00, 0, 8'h00, 1);
      chk("bp_next", data_out, 8'h6B);
      drain(6);

      // overflow and pause on lane 1 with a stalled output
      cyc(0, 0, 8'h00, 1, 8'hC0, 0);
      cyc(0, 0, 8'h00, 0, 8'h00, 0);
      chk("ovf_head", {23'd0, valid_out, sel_out, data_out}, {23'd0, 2'b11, 8'hC0});
      sb.push_back({1'b1, 8'hC0});
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) sb.push_back({1'b1, 8'hC0 + 8'(i)});
         cyc(0, 0, 8'h00, 1, 8'hC0 + 8'(i), 0);
         if (i == 2) chk("pause_below", pause_1, 0);
         if (i == 3) chk("pause_at", pause_1, 1);
         if (i == 4) chk("ovf_before", overflow_1, 0);
         if (i == 5) chk("ovf_set", overflow_1, 1);
      end
      chk("ovf_other", overflow_0, 0);
      drain(12);
      chk("ovf_sticky", overflow_1, 1);
      chk("pause_clear", pause_1, 0);

      // reset mid-operation discards everything
      cyc(0, 1, 8'hD0, 1, 8'hE0, 0);
      cyc(0, 1, 8'hD1, 1, 8'hE1, 0);
      cyc(0, 1, 8'hD2, 0, 8'h00, 0);
      chk("mid_valid", valid_out, 1);
      cyc(1, 0, 8'h00, 0, 8'h00, 0);
      chk("mid_rst_valid", valid_out, 0);
      chk("mid_rst_ovf", overflow_1, 0);
      cyc(0, 0, 8'h00, 0, 8'h00, 1);
      cyc(0, 0, 8'h00, 0, 8'h00, 1);
      chk("mid_empty", valid_out, 0);
      sb.push_back({1'b0, 8'hF0});
      sb.push_back({1'b1, 8'h70});
      cyc(0, 1, 8'hF0, 1, 8'h70, 1);
      drain(6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
